// File: rtl/clk_div_pkg.sv
// Shared types and defaults for the multi-channel programmable clock divider.
package clk_div_pkg;

    localparam int DEF_NUM_CH = 4;
    localparam int DEF_WIDTH  = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } ch_state_t;

    // Channel-select width; a single channel still needs a one-bit select.
    function automatic int ch_sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: high/low phase counter, run state machine and a
// pending configuration buffer that is applied only at period boundaries or in IDLE.
module clk_div_channel
    import clk_div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             inClk,
    input  logic             reset,
    input  logic             en,
    input  logic             wr_stb,
    input  logic [WIDTH-1:0] wr_high,
    input  logic [WIDTH-1:0] wr_low,
    output logic             clk_out,
    output logic             rise_tick,
    output logic             pending,
    output logic [1:0]       state_dbg
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    ch_state_t        state;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] active_high;
    logic [WIDTH-1:0] active_low;
    logic [WIDTH-1:0] pend_high;
    logic [WIDTH-1:0] pend_low;
    logic             pend_flag;
    logic [WIDTH-1:0] next_high;
    logic [WIDTH-1:0] next_low;

    // Lengths that govern the period starting at a LOW boundary.
    always_comb begin
        next_high = pend_flag ? pend_high : active_high;
        next_low  = pend_flag ? pend_low  : active_low;
    end

    always_ff @(posedge inClk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            count       <= '0;
            active_high <= '0;
            active_low  <= '0;
            pend_high   <= '0;
            pend_low    <= '0;
            pend_flag   <= 1'b0;
            clk_out     <= 1'b0;
            rise_tick   <= 1'b0;
        end else begin
            rise_tick <= 1'b0;
            case (state)
                IDLE: begin
                    clk_out <= 1'b0;
                    count   <= '0;
                    if (pend_flag) begin
                        active_high <= pend_high;
                        active_low  <= pend_low;
                        pend_flag   <= 1'b0;
                    end else if (en && active_high != '0 && active_low != '0) begin
                        state     <= HIGH;
                        clk_out   <= 1'b1;
                        rise_tick <= 1'b1;
                    end
                end
                HIGH: begin
                    if (count == active_high - ONE) begin
                        state   <= LOW;
                        clk_out <= 1'b0;
                        count   <= '0;
                    end else begin
                        count <= count + ONE;
                    end
                end
                LOW: begin
                    if (count == active_low - ONE) begin
                        count <= '0;
                        if (pend_flag) begin
                            active_high <= pend_high;
                            active_low  <= pend_low;
                            pend_flag   <= 1'b0;
                        end
                        if (!en || next_high == '0 || next_low == '0) begin
                            state <= IDLE;
                        end else begin
                            state     <= HIGH;
                            clk_out   <= 1'b1;
                            rise_tick <= 1'b1;
                        end
                    end else begin
                        count <= count + ONE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    clk_out <= 1'b0;
                    count   <= '0;
                end
            endcase
            // A write in the same edge as an apply wins: it refills the buffer.
            if (wr_stb) begin
                pend_high <= wr_high;
                pend_low  <= wr_low;
                pend_flag <= 1'b1;
            end
        end
    end

    assign pending   = pend_flag;
    assign state_dbg = state;

endmodule

// File: rtl/clk_divider_multi.sv
// Multi-channel programmable clock/tone generator: decodes the configuration
// write port and instantiates one independent divider per channel.
module clk_divider_multi
    import clk_div_pkg::*;
#(
    parameter  int NUM_CH = DEF_NUM_CH,
    parameter  int WIDTH  = DEF_WIDTH,
    localparam int CH_W   = ch_sel_w(NUM_CH)
) (
    input  logic              inClk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] en,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [WIDTH-1:0]  wr_high,
    input  logic [WIDTH-1:0]  wr_low,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] rise_tick,
    output logic [NUM_CH-1:0] pending,
    output logic [NUM_CH-1:0] running
);

    genvar i;
    generate
        for (i = 0; i < NUM_CH; i++) begin : g_ch
            logic       wr_stb;
            logic [1:0] state_dbg;

            // Out-of-range channel numbers match no strobe and are dropped.
            assign wr_stb = wr_en && (wr_ch == CH_W'(i));

            clk_div_channel #(
                .WIDTH(WIDTH)
            ) u_ch (
                .inClk    (inClk),
                .reset    (reset),
                .en       (en[i]),
                .wr_stb   (wr_stb),
                .wr_high  (wr_high),
                .wr_low   (wr_low),
                .clk_out  (clk_out[i]),
                .rise_tick(rise_tick[i]),
                .pending  (pending[i]),
                .state_dbg(state_dbg)
            );

            assign running[i] = (state_dbg != IDLE);
        end
    endgenerate

endmodule

// File: doc/clk_divider_multi.md
Name: clk_divider_multi

Overview:
- Multi-channel programmable clock/tone generator; each channel has independent high-phase and low-phase lengths, so duty cycle is arbitrary.
- Parameter updates are glitch-free: they are buffered and applied only at a period boundary or while the channel is idle.
- Enable deassertion finishes the current period before stopping.
- Sits beside the existing single-channel divider; feeds tone outputs, LED blinkers and peripheral strobes from the system clock.

Parameters:
- NUM_CH, 4, number of independent output channels (1..16).
- WIDTH, 32, width of the phase-length fields and counters.
- CH_W, $clog2(NUM_CH) (min 1), width of the channel select; derived, not overridden.

Ports:
- inClk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- en  in  NUM_CH  per-channel run enable.
- wr_en  in  1  write strobe for the channel-configuration interface.
- wr_ch  in  CH_W  channel addressed by the write.
- wr_high  in  WIDTH  high-phase length in inClk cycles.
- wr_low  in  WIDTH  low-phase length in inClk cycles.
- clk_out  out  NUM_CH  divided clock outputs, registered.
- rise_tick  out  NUM_CH  one-cycle pulse, high in each cycle where clk_out goes 0->1.
- pending  out  NUM_CH  a buffered configuration is waiting to be applied.
- running  out  NUM_CH  channel state is not IDLE.

Behaviour:
- Reset (async, high): every channel enters IDLE. Counter, active and pending lengths = 0. Outputs clk_out, rise_tick, pending and running = 0.
- Per-channel registers: active_high, active_low, pend_high, pend_low, pend_flag, count (WIDTH bits), state in {IDLE, HIGH, LOW}.
- Write: when wr_en=1 and wr_ch<NUM_CH, at the edge pend_high/pend_low <= wr_high/wr_low and pend_flag <= 1.
  - Last write wins.
  - wr_ch>=NUM_CH is ignored.
  - pending = pend_flag.
- IDLE:
  - clk_out=0, count=0.
  - If pend_flag: copy pending to active, clear pend_flag, stay IDLE this edge.
  - Else if en=1 and active_high!=0 and active_low!=0: go to HIGH, clk_out<=1, rise_tick<=1, count<=0.
  - Latency from write edge to clk_out=1 is 2 edges (write captured, apply, start).
- HIGH:
  - If count==active_high-1: go to LOW, clk_out<=0, count<=0.
  - Else count<=count+1.
  - en is ignored here.
- LOW (period boundary at count==active_low-1):
  - If pend_flag, apply pending first (active <= pending, clear flag); evaluate the rest of the boundary with the new values.
  - If en=0 or either new length is 0: go to IDLE, clk_out stays 0.
  - Else go to HIGH, clk_out<=1, rise_tick<=1, count<=0.
  - Not at the boundary: count<=count+1.
- Resulting waveform: clk_out high exactly active_high cycles and low exactly active_low cycles; period = high+low. Length 1 gives single-cycle phases (e.g. high=1, low=1 gives inClk/2).
- rise_tick is registered and asserted in the same cycle clk_out first reads 1; it is 0 otherwise.
- Simultaneous write and boundary on the same channel: the boundary uses the pending value registered before that edge. The new write lands in pending with pend_flag=1 and is applied at the next boundary or in IDLE.
- en falling mid-period: the period completes (HIGH then LOW), then the channel goes IDLE. There are no runt pulses.
- Reset asserted mid-operation: immediate return to reset values regardless of inClk.
- Counter arithmetic is WIDTH-bit unsigned. Comparisons are against length-1 with length!=0 guaranteed on entry, so there is no wrap.

Decomposition:
- Package clk_div_pkg:
  - state enum ch_state_t {IDLE, HIGH, LOW}.
  - default WIDTH/NUM_CH localparams.
- Sub-module clk_div_channel: one channel's counter, state machine and pending buffer, with a per-channel write strobe.
- Top: decodes wr_ch and instantiates NUM_CH channels via generate.

Test Plan:
- Reset then write ch0 high=2 low=3, en[0]=1 -> clk_out[0] first rises 2 edges after the write; thereafter 2 cycles high, 3 low, period 5; rise_tick[0] pulses once per period; other channels stay 0.
- ch1 high=1 low=1 -> clk_out[1] toggles every cycle (inClk/2). Simultaneously ch2 high=4 low=4 -> period 8, with no cross-channel interference.
- Reconfigure ch0 to high=5 low=1 mid-HIGH -> pending[0]=1 until the end of the current LOW phase; the next period is 5 high / 1 low with no shortened phase.
- Deassert en[0] one cycle into HIGH (high=3, low=3) -> the full 3-high/3-low period completes, then running[0]=0 and clk_out[0] holds 0.
- Write high=0 low=7 to a running channel -> the channel enters IDLE at the boundary; write wr_ch=NUM_CH -> no pending/state change.
- Assert reset asynchronously between edges while clk_out=1 -> all outputs go 0 immediately. Write coinciding with the boundary edge -> that boundary keeps the old values, and the new values apply at the following boundary.
